// File: rtl/audio_frame_sequencer.sv
// Per-frame sequencer: pops a stereo frame, runs it through the effect chain, pushes the result.
// Define FX_DEBOUNCE_EN to debounce the effect-enable switches before they are latched.
module audio_frame_sequencer #(
    parameter int TIMEOUT         = 2048,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [9:0]         SW,
    input  logic               audio_in_available,
    input  logic               audio_out_allowed,
    input  logic signed [31:0] audio_in_L,
    input  logic signed [31:0] audio_in_R,
    output logic               read_audio_in,
    output logic               write_audio_out,
    output logic signed [31:0] audio_out_L,
    output logic signed [31:0] audio_out_R,
    output logic signed [31:0] chain_in_L,
    output logic signed [31:0] chain_in_R,
    output logic               chain_start,
    input  logic               chain_done,
    input  logic signed [31:0] chain_out_L,
    input  logic signed [31:0] chain_out_R,
    output logic [3:0]         fx_enable,
    output logic               busy,
    output logic [15:0]        drop_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PROC     = 2'd1;
    localparam logic [1:0] WAIT_OUT = 2'd2;
    localparam logic [1:0] WRITE    = 2'd3;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]                  state;
    logic [TW-1:0]               tcnt;
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  sw_s;
    logic [3:0]                  sw_fx;
    logic                        unused_sw;

    assign unused_sw = ^SW[9:4];

    always_ff @(posedge CLOCK_50) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], SW[3:0]};
    end
    assign sw_s = sync_q[SYNC_STAGES-1];

`ifdef FX_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Each switch flips its stable value only after a full quiet run of disagreement.
    for (genvar g = 0; g < 4; g++) begin : g_db
        logic [DW-1:0] cnt;
        logic          stable;
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sw_s[g] == stable) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt    <= '0;
                stable <= sw_s[g];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign sw_fx[g] = stable;
    end
`else
    logic unused_db;
    assign unused_db = DEBOUNCE_CYCLES[0];
    assign sw_fx     = sw_s;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            tcnt            <= '0;
            read_audio_in   <= 1'b0;
            chain_start     <= 1'b0;
            write_audio_out <= 1'b0;
            audio_out_L     <= '0;
            audio_out_R     <= '0;
            chain_in_L      <= '0;
            chain_in_R      <= '0;
            fx_enable       <= '0;
            drop_count      <= '0;
        end else begin
            read_audio_in   <= 1'b0;
            chain_start     <= 1'b0;
            write_audio_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (audio_in_available) begin
                        chain_in_L    <= audio_in_L;
                        chain_in_R    <= audio_in_R;
                        fx_enable     <= sw_fx;
                        read_audio_in <= 1'b1;
                        chain_start   <= 1'b1;
                        tcnt          <= '0;
                        state         <= PROC;
                        busy          <= 1'b1;
                    end
                end
                PROC: begin
                    // A done on the final counted cycle still beats the timeout.
                    if (chain_done) begin
                        audio_out_L <= chain_out_L;
                        audio_out_R <= chain_out_R;
                        state       <= WAIT_OUT;
                    end else if (tcnt == T_LAST) begin
                        audio_out_L <= '0;
                        audio_out_R <= '0;
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        state <= WAIT_OUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_OUT: begin
                    if (audio_out_allowed) begin
                        write_audio_out <= 1'b1;
                        state           <= WRITE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
